// File: rtl/memtrace_lane_serializer_pkg.sv
// Shared types and defaults for the memory-trace lane serializer.
package memtrace_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_LOGSIZE_WIDTH = 8;
  localparam int MAX_NUM_LANES     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // One captured lane request at the default widths.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]    address;
    logic                         is_store;
    logic [DEF_LOGSIZE_WIDTH-1:0] size;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } lane_req_t;

  // Lane index width; a single-lane build still gets a 1-bit id.
  function automatic int lane_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memtrace_lane_serializer_if.sv
// Trace-batch input, memory request output and response strobe.
// Lane g of each packed vector sits at bits [W*(g+1)-1 : W*g].
interface memtrace_lane_serializer_if #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = memtrace_pkg::DEF_DATA_WIDTH,
  parameter int LOGSIZE_WIDTH = memtrace_pkg::DEF_LOGSIZE_WIDTH
);
  localparam int LANE_W = memtrace_pkg::lane_id_w(NUM_LANES);

  logic                                       trace_read_ready;
  logic [NUM_LANES-1:0]                       trace_read_valid;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]       trace_read_address;
  logic [NUM_LANES-1:0]                       trace_read_is_store;
  logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0]    trace_read_size;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]       trace_read_data;
  logic                                       trace_read_finished;

  logic                                       req_valid;
  logic                                       req_ready;
  logic [LANE_W-1:0]                          req_lane_id;
  logic [DATA_WIDTH-1:0]                      req_address;
  logic                                       req_is_store;
  logic [LOGSIZE_WIDTH-1:0]                   req_size;
  logic [DATA_WIDTH-1:0]                      req_data;

  logic                                       resp_valid;

  // Serializer side.
  modport master (
    output trace_read_ready,
    input  trace_read_valid, trace_read_address, trace_read_is_store,
    input  trace_read_size, trace_read_data, trace_read_finished,
    output req_valid, req_lane_id, req_address, req_is_store, req_size, req_data,
    input  req_ready,
    input  resp_valid
  );

  // Trace source / memory side.
  modport slave (
    input  trace_read_ready,
    output trace_read_valid, trace_read_address, trace_read_is_store,
    output trace_read_size, trace_read_data, trace_read_finished,
    input  req_valid, req_lane_id, req_address, req_is_store, req_size, req_data,
    output req_ready,
    output resp_valid
  );

endinterface

// File: rtl/memtrace_lane_picker.sv
// Lowest-index priority encoder over the pending-lane mask.
module memtrace_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_LANES-1:0] mask,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/memtrace_lane_serializer.sv
// Captures one multi-lane trace batch, issues it one lane per handshake
// on a single memory port and tracks in-flight responses to completion.
module memtrace_lane_serializer
  import memtrace_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LOGSIZE_WIDTH   = DEF_LOGSIZE_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  memtrace_lane_serializer_if.master       bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             done,
  output logic                             resp_error
);

  localparam int LANE_W = lane_id_w(NUM_LANES);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  state_e                                  state_q, state_d;
  logic [NUM_LANES-1:0]                    pend_q, pend_d;
  logic                                    fin_pend_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    addr_q, data_q;
  logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0] size_q;
  logic [NUM_LANES-1:0]                    store_q;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    err_q, err_d;

  logic [LANE_W-1:0]                       sel;
  logic [NUM_LANES-1:0]                    sel_oh;
  logic                                    any_pend;
  logic                                    in_drain, can_issue, issue, resp;
  logic                                    capture, last;

  memtrace_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (LANE_W)
  ) u_pick (
    .mask (pend_q),
    .idx  (sel),
    .any  (any_pend)
  );

  assign sel_oh    = NUM_LANES'(1) << sel;
  assign in_drain  = (state_q == ST_DRAIN);
  // Issue eligibility looks only at registered state, never at req_ready.
  assign can_issue = in_drain && any_pend && (cnt_q < CNT_MAX);
  assign issue     = can_issue && bus.req_ready;
  assign resp      = bus.resp_valid && (state_q != ST_IDLE);
  assign capture   = (state_q == ST_FETCH) && (|bus.trace_read_valid);
  assign pend_d    = pend_q & ~sel_oh;
  assign last      = issue && (pend_d == '0);

  assign bus.trace_read_ready = (state_q == ST_FETCH);
  assign bus.req_valid        = can_issue;
  // Request fields come from captured registers, so they hold through a stall.
  assign bus.req_lane_id      = in_drain ? sel          : '0;
  assign bus.req_address      = in_drain ? addr_q[sel]  : '0;
  assign bus.req_is_store     = in_drain ? store_q[sel] : 1'b0;
  assign bus.req_size         = in_drain ? size_q[sel]  : '0;
  assign bus.req_data         = in_drain ? data_q[sel]  : '0;

  assign outstanding = cnt_q;
  assign done        = (state_q == ST_DONE);
  assign resp_error  = err_q;

  // In-flight count: issue and response together cancel; a response with
  // nothing in flight is flagged instead of underflowing.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (issue && !resp) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && resp) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Sequencing: fetch a batch, drain it lane by lane, flush responses.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (|bus.trace_read_valid)    state_d = ST_DRAIN;
        else if (bus.trace_read_finished) state_d = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (last) state_d = fin_pend_q ? ST_FLUSH : ST_FETCH;
      end
      ST_FLUSH: begin
        if (cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, pending mask, finish latch and response counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      fin_pend_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        pend_q     <= bus.trace_read_valid;
        fin_pend_q <= bus.trace_read_finished;
      end else if (issue) begin
        pend_q <= pend_d;
      end
    end
  end

  // Per-lane field capture; only the FETCH handshake loads it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      store_q <= '0;
    end else if (capture) begin
      addr_q  <= bus.trace_read_address;
      data_q  <= bus.trace_read_data;
      size_q  <= bus.trace_read_size;
      store_q <= bus.trace_read_is_store;
    end
  end

endmodule

// File: tb/tb_memtrace_lane_serializer.sv
// Directed bench: two serializers (8-deep and 2-deep in-flight limit),
// expected lane requests queued at stimulus time and popped by monitors.
module tb_memtrace_lane_serializer;
  import memtrace_pkg::*;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int SW = 8;

  typedef struct packed {
    logic [1:0] lane;
    lane_req_t  r;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memtrace_lane_serializer_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW)) ba ();
  memtrace_lane_serializer_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW)) bb ();

  logic [3:0] outa;
  logic [1:0] outb;
  logic       donea, doneb, erra, errb;

  memtrace_lane_serializer #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .MAX_OUTSTANDING(8)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(ba),
    .outstanding(outa), .done(donea), .resp_error(erra)
  );

  memtrace_lane_serializer #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(bb),
    .outstanding(outb), .done(doneb), .resp_error(errb)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic lane_req_t mk(input logic [63:0] base, input int g);
    lane_req_t r;
    r.address  = base + 64'(g) * 64'h40;
    r.is_store = g[0];
    r.size     = 8'(g + 1);
    r.data     = ~r.address ^ {32'h5A5A_0000, 32'(g)};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon_cmp(input string nm, input exp_t e, input logic [1:0] lane,
                         input logic [63:0] addr, input logic st, input logic [7:0] sz,
                         input logic [63:0] dat);
    total++;
    if (lane !== e.lane || addr !== e.r.address || st !== e.r.is_store ||
        sz !== e.r.size || dat !== e.r.data) begin
      bad++;
      $display("FAIL %s issue: got lane=%0d addr=%h st=%b sz=%0d data=%h, want lane=%0d addr=%h st=%b sz=%0d data=%h",
               nm, lane, addr, st, sz, dat, e.lane, e.r.address, e.r.is_store, e.r.size, e.r.data);
    end
  endtask

  // Present a batch on one DUT; queue expected issues in lane order.
  task automatic load(input bit sel_b, input logic [NL-1:0] mask, input logic [63:0] base,
                      input logic fin, input bit push);
    lane_req_t r;
    exp_t      e;
    for (int g = 0; g < NL; g++) begin
      r = mk(base, g);
      if (sel_b) begin
        bb.trace_read_address[g]  = r.address;
        bb.trace_read_is_store[g] = r.is_store;
        bb.trace_read_size[g]     = r.size;
        bb.trace_read_data[g]     = r.data;
      end else begin
        ba.trace_read_address[g]  = r.address;
        ba.trace_read_is_store[g] = r.is_store;
        ba.trace_read_size[g]     = r.size;
        ba.trace_read_data[g]     = r.data;
      end
      if (push && mask[g]) begin
        e.lane = 2'(g);
        e.r    = r;
        if (sel_b) qb.push_back(e);
        else       qa.push_back(e);
      end
    end
    if (sel_b) begin
      bb.trace_read_valid    = mask;
      bb.trace_read_finished = fin;
    end else begin
      ba.trace_read_valid    = mask;
      ba.trace_read_finished = fin;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitors: every accepted request must match the head of its queue.
  always @(negedge clock) begin
    if (reset && ba.req_valid && ba.req_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_a: got unexpected issue lane=%0d want none", ba.req_lane_id);
      end else begin
        mon_cmp("mon_a", qa.pop_front(), ba.req_lane_id, ba.req_address,
                ba.req_is_store, ba.req_size, ba.req_data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && bb.req_valid && bb.req_ready) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_b: got unexpected issue lane=%0d want none", bb.req_lane_id);
      end else begin
        mon_cmp("mon_b", qb.pop_front(), bb.req_lane_id, bb.req_address,
                bb.req_is_store, bb.req_size, bb.req_data);
      end
    end
  end

  initial begin
    lane_req_t t;
    ba.trace_read_valid = '0; ba.trace_read_finished = 1'b0;
    ba.trace_read_address = '0; ba.trace_read_data = '0;
    ba.trace_read_size = '0; ba.trace_read_is_store = '0;
    ba.req_ready = 1'b0; ba.resp_valid = 1'b0;
    bb.trace_read_valid = '0; bb.trace_read_finished = 1'b0;
    bb.trace_read_address = '0; bb.trace_read_data = '0;
    bb.trace_read_size = '0; bb.trace_read_is_store = '0;
    bb.req_ready = 1'b0; bb.resp_valid = 1'b0;

    // Reset values.
    cyc(); cyc();
    chk("rst_ready",  64'(ba.trace_read_ready), 0);
    chk("rst_valid",  64'(ba.req_valid), 0);
    chk("rst_addr",   ba.req_address, 0);
    chk("rst_lane",   64'(ba.req_lane_id), 0);
    chk("rst_out",    64'(outa), 0);
    chk("rst_done",   64'(donea), 0);
    chk("rst_err",    64'(erra), 0);
    reset = 1'b1;
    chk("idle_ready", 64'(ba.trace_read_ready), 0);
    cyc();
    chk("fetch_ready_a", 64'(ba.trace_read_ready), 1);
    chk("fetch_ready_b", 64'(bb.trace_read_ready), 1);

    // Batch 1011 with full-rate memory and responses two cycles after issue.
    load(0, 4'b1011, 64'h0000_1000_0000_0000, 1'b0, 1);
    ba.req_ready = 1'b1;
    cyc();
    ba.trace_read_valid = '0;
    chk("b1_ready_lo", 64'(ba.trace_read_ready), 0);
    chk("b1_latency",  64'(ba.req_valid), 1);
    chk("b1_out0",     64'(outa), 0);
    cyc();
    chk("b1_out1", 64'(outa), 1);
    cyc();
    ba.resp_valid = 1'b1;
    chk("b1_lane3", 64'(ba.req_lane_id), 3);
    cyc();
    chk("b1_ready_hi", 64'(ba.trace_read_ready), 1);
    chk("b1_out_pair", 64'(outa), 2);
    cyc();
    chk("b1_out_dec", 64'(outa), 1);
    cyc();
    ba.resp_valid = 1'b0;
    chk("b1_out_zero", 64'(outa), 0);

    // Backpressure on lane 1 for five cycles.
    load(0, 4'b0111, 64'h0000_2000_0000_0000, 1'b0, 1);
    t = mk(64'h0000_2000_0000_0000, 1);
    cyc();
    ba.trace_read_valid = '0;
    cyc();
    ba.req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(ba.req_valid), 1);
      chk("bp_lane",  64'(ba.req_lane_id), 1);
      chk("bp_addr",  ba.req_address, t.address);
      chk("bp_data",  ba.req_data, t.data);
      chk("bp_out",   64'(outa), 1);
      cyc();
    end
    ba.req_ready = 1'b1;
    cyc();
    cyc();
    chk("bp_ready_hi", 64'(ba.trace_read_ready), 1);
    chk("bp_out3",     64'(outa), 3);
    ba.resp_valid = 1'b1;
    repeat (3) cyc();
    ba.resp_valid = 1'b0;
    chk("bp_out_zero", 64'(outa), 0);

    // Stray response with nothing in flight.
    chk("err_pre", 64'(erra), 0);
    ba.resp_valid = 1'b1;
    cyc();
    ba.resp_valid = 1'b0;
    chk("err_set",  64'(erra), 1);
    chk("err_out0", 64'(outa), 0);

    // Issue and response in the same cycle at outstanding 1.
    load(0, 4'b0011, 64'h0000_3000_0000_0000, 1'b0, 1);
    cyc();
    ba.trace_read_valid = '0;
    cyc();
    chk("sim_out_pre", 64'(outa), 1);
    ba.resp_valid = 1'b1;
    cyc();
    chk("sim_out_hold", 64'(outa), 1);
    cyc();
    ba.resp_valid = 1'b0;
    chk("sim_out_zero", 64'(outa), 0);
    chk("err_sticky",   64'(erra), 1);

    // Finish together with a single-lane batch, then flush to done.
    load(0, 4'b0001, 64'h0000_4000_0000_0000, 1'b1, 1);
    cyc();
    ba.trace_read_valid = '0;
    ba.trace_read_finished = 1'b0;
    chk("fin_issue", 64'(ba.req_valid), 1);
    cyc();
    chk("flush_ready", 64'(ba.trace_read_ready), 0);
    chk("flush_valid", 64'(ba.req_valid), 0);
    chk("flush_done",  64'(donea), 0);
    chk("flush_out",   64'(outa), 1);
    cyc(); cyc();
    chk("flush_wait_done", 64'(donea), 0);
    ba.resp_valid = 1'b1;
    cyc();
    ba.resp_valid = 1'b0;
    chk("done_set",   64'(donea), 1);
    chk("done_out",   64'(outa), 0);
    chk("done_ready", 64'(ba.trace_read_ready), 0);
    cyc(); cyc();
    chk("done_sticky", 64'(donea), 1);

    // Two-deep limit on the second DUT, no early responses.
    load(1, 4'b1111, 64'h0000_5000_0000_0000, 1'b0, 1);
    bb.req_ready = 1'b1;
    cyc();
    bb.trace_read_valid = '0;
    chk("cap_v0", 64'(bb.req_valid), 1);
    cyc();
    cyc();
    chk("cap_out2",    64'(outb), 2);
    chk("cap_blocked", 64'(bb.req_valid), 0);
    cyc();
    chk("cap_blocked2", 64'(bb.req_valid), 0);
    bb.resp_valid = 1'b1;
    cyc();
    bb.resp_valid = 1'b0;
    chk("cap_out1",    64'(outb), 1);
    chk("cap_resume",  64'(bb.req_valid), 1);
    chk("cap_lane2",   64'(bb.req_lane_id), 2);
    cyc();
    chk("cap_reblock", 64'(bb.req_valid), 0);
    bb.resp_valid = 1'b1;
    cyc();
    bb.resp_valid = 1'b0;
    chk("cap_lane3", 64'(bb.req_lane_id), 3);
    cyc();
    chk("cap_fetch", 64'(bb.trace_read_ready), 1);
    chk("cap_outf",  64'(outb), 2);

    // Reset while two lanes sit pending behind the limit.
    load(1, 4'b0110, 64'h0000_6000_0000_0000, 1'b0, 0);
    cyc();
    bb.trace_read_valid = '0;
    chk("mr_stalled", 64'(bb.req_valid), 0);
    reset = 1'b0;
    #1;
    chk("mr_ready",  64'(bb.trace_read_ready), 0);
    chk("mr_valid",  64'(bb.req_valid), 0);
    chk("mr_out",    64'(outb), 0);
    chk("mr_lane",   64'(bb.req_lane_id), 0);
    chk("mr_addr",   bb.req_address, 0);
    chk("mr_done_a", 64'(donea), 0);
    chk("mr_err_a",  64'(erra), 0);
    cyc(); cyc();
    chk("mr_hold_valid", 64'(bb.req_valid), 0);
    reset = 1'b1;
    chk("mr_idle_ready", 64'(bb.trace_read_ready), 0);
    cyc();
    chk("mr_fetch_ready", 64'(bb.trace_read_ready), 1);
    chk("mr_no_issue",    64'(bb.req_valid), 0);
    cyc(); cyc();
    chk("mr_still_idle",  64'(bb.req_valid), 0);

    chk("qa_empty", 64'(qa.size()), 0);
    chk("qb_empty", 64'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
